// File: rtl/forward_window_updater_pkg.sv
// hash_fwd_pkg: shared defaults and helpers for the cuckoo-hash write-forwarding stage.
// Contents:
//   DEF_* localparams : default widths and sizes used by the forwarding stage
//   count_ones()      : population count, used for hit statistics downstream
package hash_fwd_pkg;

    localparam int DEF_DATA_WIDTH       = 4;
    localparam int DEF_KEY_WIDTH        = 2;
    localparam int DEF_ADR_WIDTH        = 2;
    localparam int DEF_NUMBER_OF_TABLES = 4;
    localparam int DEF_DEPTH            = 2;
    localparam int DEF_CNT_WIDTH        = 16;

    // Number of set bits in a vector of up to 64 bits (zero-extend narrower inputs).
    function automatic int unsigned count_ones(input logic [63:0] vec);
        int unsigned n;
        n = 32'd0;
        for (int i = 0; i < 64; i++) begin
            n = n + {31'd0, vec[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/forward_window_updater_if.sv
// forward_window_updater_if: bundles the control, write-back, raw read and
// corrected output signals of the forwarding stage.
// Modports:
//   master : drives controls, write-backs and raw read results; receives the corrected beat
//   slave  : the forwarding stage itself
// Signals (T = NUMBER_OF_TABLES, all per-table vectors are packed with table t at index t):
//   clk_en, flush_i, wr_we_i/adr/key/data/valid, rd_req_i, rd_adr/key/data/valid,
//   out_valid_o, out_key/data/is_valid_o, out_fwd_hit_o, hit_count_o
interface forward_window_updater_if
    import hash_fwd_pkg::*;
#(
    parameter int NUMBER_OF_TABLES = DEF_NUMBER_OF_TABLES,
    parameter int ADR_WIDTH        = DEF_ADR_WIDTH,
    parameter int KEY_WIDTH        = DEF_KEY_WIDTH,
    parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH        = DEF_CNT_WIDTH
);
    logic                                         clk_en;
    logic                                         flush_i;
    logic [NUMBER_OF_TABLES-1:0]                  wr_we_i;
    logic [NUMBER_OF_TABLES-1:0][ADR_WIDTH-1:0]   wr_adr_i;
    logic [NUMBER_OF_TABLES-1:0][KEY_WIDTH-1:0]   wr_key_i;
    logic [NUMBER_OF_TABLES-1:0][DATA_WIDTH-1:0]  wr_data_i;
    logic [NUMBER_OF_TABLES-1:0]                  wr_valid_i;
    logic                                         rd_req_i;
    logic [NUMBER_OF_TABLES-1:0][ADR_WIDTH-1:0]   rd_adr_i;
    logic [NUMBER_OF_TABLES-1:0][KEY_WIDTH-1:0]   rd_key_i;
    logic [NUMBER_OF_TABLES-1:0][DATA_WIDTH-1:0]  rd_data_i;
    logic [NUMBER_OF_TABLES-1:0]                  rd_valid_i;
    logic                                         out_valid_o;
    logic [NUMBER_OF_TABLES-1:0][KEY_WIDTH-1:0]   out_key_o;
    logic [NUMBER_OF_TABLES-1:0][DATA_WIDTH-1:0]  out_data_o;
    logic [NUMBER_OF_TABLES-1:0]                  out_is_valid_o;
    logic [NUMBER_OF_TABLES-1:0]                  out_fwd_hit_o;
    logic [CNT_WIDTH-1:0]                         hit_count_o;

    modport master (
        output clk_en, flush_i,
        output wr_we_i, wr_adr_i, wr_key_i, wr_data_i, wr_valid_i,
        output rd_req_i, rd_adr_i, rd_key_i, rd_data_i, rd_valid_i,
        input  out_valid_o, out_key_o, out_data_o, out_is_valid_o, out_fwd_hit_o, hit_count_o
    );

    modport slave (
        input  clk_en, flush_i,
        input  wr_we_i, wr_adr_i, wr_key_i, wr_data_i, wr_valid_i,
        input  rd_req_i, rd_adr_i, rd_key_i, rd_data_i, rd_valid_i,
        output out_valid_o, out_key_o, out_data_o, out_is_valid_o, out_fwd_hit_o, hit_count_o
    );

endinterface

// File: rtl/forward_window_updater_match_chain.sv
// fwd_match_chain: combinational priority match for one table. Candidates are
// history slots 0 (oldest) .. DEPTH-1 plus the current-cycle write (newest).
// The newest candidate whose we is set and whose address equals rd_adr_i
// supplies key/data/valid; otherwise the raw RAM result passes through.
// Ports:
//   cur_*_i  : write issued this cycle
//   hist_*_i : history slots, index DEPTH-1 newest
//   rd_*_i   : raw RAM read result and read address
//   hit_o, key_o, data_o, valid_o : corrected result
module fwd_match_chain
    import hash_fwd_pkg::*;
#(
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADR_WIDTH  = DEF_ADR_WIDTH,
    parameter int KEY_WIDTH  = DEF_KEY_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                             cur_we_i,
    input  logic [ADR_WIDTH-1:0]             cur_adr_i,
    input  logic [KEY_WIDTH-1:0]             cur_key_i,
    input  logic [DATA_WIDTH-1:0]            cur_data_i,
    input  logic                             cur_valid_i,
    input  logic [DEPTH-1:0]                 hist_we_i,
    input  logic [DEPTH-1:0][ADR_WIDTH-1:0]  hist_adr_i,
    input  logic [DEPTH-1:0][KEY_WIDTH-1:0]  hist_key_i,
    input  logic [DEPTH-1:0][DATA_WIDTH-1:0] hist_data_i,
    input  logic [DEPTH-1:0]                 hist_valid_i,
    input  logic [ADR_WIDTH-1:0]             rd_adr_i,
    input  logic [KEY_WIDTH-1:0]             rd_key_i,
    input  logic [DATA_WIDTH-1:0]            rd_data_i,
    input  logic                             rd_valid_i,
    output logic                             hit_o,
    output logic [KEY_WIDTH-1:0]             key_o,
    output logic [DATA_WIDTH-1:0]            data_o,
    output logic                             valid_o
);
    // Candidate index DEPTH is the current write, so ascending index = ascending age priority.
    logic [DEPTH:0]                 cand_we_s;
    logic [DEPTH:0][ADR_WIDTH-1:0]  cand_adr_s;
    logic [DEPTH:0][KEY_WIDTH-1:0]  cand_key_s;
    logic [DEPTH:0][DATA_WIDTH-1:0] cand_data_s;
    logic [DEPTH:0]                 cand_valid_s;

    logic                  hit_s;
    logic [KEY_WIDTH-1:0]  key_s;
    logic [DATA_WIDTH-1:0] data_s;
    logic                  valid_s;

    assign cand_we_s    = {cur_we_i,    hist_we_i};
    assign cand_adr_s   = {cur_adr_i,   hist_adr_i};
    assign cand_key_s   = {cur_key_i,   hist_key_i};
    assign cand_data_s  = {cur_data_i,  hist_data_i};
    assign cand_valid_s = {cur_valid_i, hist_valid_i};

    // Walk oldest to newest so the last (newest) matching candidate wins; a
    // matching delete (valid=0) still overrides, which makes deletes visible.
    always_comb begin
        hit_s   = 1'b0;
        key_s   = rd_key_i;
        data_s  = rd_data_i;
        valid_s = rd_valid_i;
        for (int i = 0; i <= DEPTH; i++) begin
            if (cand_we_s[i] && (cand_adr_s[i] == rd_adr_i)) begin
                hit_s   = 1'b1;
                key_s   = cand_key_s[i];
                data_s  = cand_data_s[i];
                valid_s = cand_valid_s[i];
            end else begin
                hit_s   = hit_s;
                key_s   = key_s;
                data_s  = data_s;
                valid_s = valid_s;
            end
        end
    end

    assign hit_o   = hit_s;
    assign key_o   = key_s;
    assign data_o  = data_s;
    assign valid_o = valid_s;

endmodule

// File: rtl/forward_window_updater.sv
// forward_window_updater: write-forwarding stage between the table RAM read
// ports and the cuckoo insert/lookup logic. Keeps the last DEPTH write-backs per
// table and patches read results that a not-yet-visible write made stale.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : forward_window_updater_if.slave (controls, write-backs, raw reads, corrected outputs)
// Behaviour: 1-cycle latency rd_* -> out_*; clk_en=0 freezes all state;
// flush_i clears the window (the current write is not captured but is still
// forwarded to a same-cycle read); hit_count_o saturates at all-ones.
module forward_window_updater
    import hash_fwd_pkg::*;
#(
    parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
    parameter int KEY_WIDTH        = DEF_KEY_WIDTH,
    parameter int NUMBER_OF_TABLES = DEF_NUMBER_OF_TABLES,
    parameter int ADR_WIDTH        = DEF_ADR_WIDTH,
    parameter int DEPTH            = DEF_DEPTH,
    parameter int CNT_WIDTH        = DEF_CNT_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    forward_window_updater_if.slave  bus
);
    localparam int T = NUMBER_OF_TABLES;

    typedef struct packed {
        logic                  we;
        logic [ADR_WIDTH-1:0]  adr;
        logic [KEY_WIDTH-1:0]  key;
        logic [DATA_WIDTH-1:0] data;
        logic                  valid;
    } slot_t;

    slot_t [T-1:0][DEPTH-1:0] hist_q, hist_d;

    logic                             out_valid_q, out_valid_d;
    logic [T-1:0][KEY_WIDTH-1:0]      out_key_q, out_key_d;
    logic [T-1:0][DATA_WIDTH-1:0]     out_data_q, out_data_d;
    logic [T-1:0]                     out_is_valid_q, out_is_valid_d;
    logic [T-1:0]                     out_hit_q, out_hit_d;
    logic [CNT_WIDTH-1:0]             cnt_q, cnt_d;

    logic [T-1:0]                     hit_s;
    logic [T-1:0][KEY_WIDTH-1:0]      corr_key_s;
    logic [T-1:0][DATA_WIDTH-1:0]     corr_data_s;
    logic [T-1:0]                     corr_valid_s;

    for (genvar t = 0; t < T; t++) begin : g_tbl
        logic [DEPTH-1:0]                 h_we_s;
        logic [DEPTH-1:0][ADR_WIDTH-1:0]  h_adr_s;
        logic [DEPTH-1:0][KEY_WIDTH-1:0]  h_key_s;
        logic [DEPTH-1:0][DATA_WIDTH-1:0] h_data_s;
        logic [DEPTH-1:0]                 h_valid_s;

        // Unpack history slots; a flush hides the whole window from the same-cycle read.
        always_comb begin
            for (int i = 0; i < DEPTH; i++) begin
                h_we_s[i]    = hist_q[t][i].we & ~bus.flush_i;
                h_adr_s[i]   = hist_q[t][i].adr;
                h_key_s[i]   = hist_q[t][i].key;
                h_data_s[i]  = hist_q[t][i].data;
                h_valid_s[i] = hist_q[t][i].valid;
            end
        end

        fwd_match_chain #(
            .DEPTH      (DEPTH),
            .ADR_WIDTH  (ADR_WIDTH),
            .KEY_WIDTH  (KEY_WIDTH),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_chain (
            .cur_we_i     (bus.wr_we_i[t]),
            .cur_adr_i    (bus.wr_adr_i[t]),
            .cur_key_i    (bus.wr_key_i[t]),
            .cur_data_i   (bus.wr_data_i[t]),
            .cur_valid_i  (bus.wr_valid_i[t]),
            .hist_we_i    (h_we_s),
            .hist_adr_i   (h_adr_s),
            .hist_key_i   (h_key_s),
            .hist_data_i  (h_data_s),
            .hist_valid_i (h_valid_s),
            .rd_adr_i     (bus.rd_adr_i[t]),
            .rd_key_i     (bus.rd_key_i[t]),
            .rd_data_i    (bus.rd_data_i[t]),
            .rd_valid_i   (bus.rd_valid_i[t]),
            .hit_o        (hit_s[t]),
            .key_o        (corr_key_s[t]),
            .data_o       (corr_data_s[t]),
            .valid_o      (corr_valid_s[t])
        );
    end

    // Next-state: shift window, load output register and bump the saturating counter when enabled.
    always_comb begin
        hist_d         = hist_q;
        out_valid_d    = out_valid_q;
        out_key_d      = out_key_q;
        out_data_d     = out_data_q;
        out_is_valid_d = out_is_valid_q;
        out_hit_d      = out_hit_q;
        cnt_d          = cnt_q;
        if (bus.clk_en) begin
            for (int t = 0; t < T; t++) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    hist_d[t][i]    = hist_q[t][i+1];
                    hist_d[t][i].we = hist_q[t][i+1].we & ~bus.flush_i;
                end
                // Flush drops the incoming write too, so the window is empty afterwards.
                hist_d[t][DEPTH-1] = '{we:    bus.wr_we_i[t] & ~bus.flush_i,
                                       adr:   bus.wr_adr_i[t],
                                       key:   bus.wr_key_i[t],
                                       data:  bus.wr_data_i[t],
                                       valid: bus.wr_valid_i[t]};
            end
            out_valid_d    = bus.rd_req_i;
            out_key_d      = corr_key_s;
            out_data_d     = corr_data_s;
            out_is_valid_d = corr_valid_s;
            out_hit_d      = hit_s;
            if (bus.rd_req_i && (|hit_s) && !(&cnt_q)) begin
                cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            hist_d = hist_q;
            cnt_d  = cnt_q;
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q         <= '0;
            out_valid_q    <= 1'b0;
            out_key_q      <= '0;
            out_data_q     <= '0;
            out_is_valid_q <= '0;
            out_hit_q      <= '0;
            cnt_q          <= '0;
        end else begin
            hist_q         <= hist_d;
            out_valid_q    <= out_valid_d;
            out_key_q      <= out_key_d;
            out_data_q     <= out_data_d;
            out_is_valid_q <= out_is_valid_d;
            out_hit_q      <= out_hit_d;
            cnt_q          <= cnt_d;
        end
    end

    assign bus.out_valid_o    = out_valid_q;
    assign bus.out_key_o      = out_key_q;
    assign bus.out_data_o     = out_data_q;
    assign bus.out_is_valid_o = out_is_valid_q;
    assign bus.out_fwd_hit_o  = out_hit_q;
    assign bus.hit_count_o    = cnt_q;

endmodule

// File: tb/tb_forward_window_updater.sv
// Directed bench for forward_window_updater: T=4, DEPTH=2, DATA=4, KEY=2, ADR=2, CNT=2.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_forward_window_updater;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    forward_window_updater_if #(
        .NUMBER_OF_TABLES (4), .ADR_WIDTH (2), .KEY_WIDTH (2),
        .DATA_WIDTH (4), .CNT_WIDTH (2)
    ) bif ();

    forward_window_updater #(
        .DATA_WIDTH (4), .KEY_WIDTH (2), .NUMBER_OF_TABLES (4),
        .ADR_WIDTH (2), .DEPTH (2), .CNT_WIDTH (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bif.clk_en     = 1'b1;
        bif.flush_i    = 1'b0;
        bif.wr_we_i    = '0;
        bif.wr_adr_i   = '0;
        bif.wr_key_i   = '0;
        bif.wr_data_i  = '0;
        bif.wr_valid_i = '0;
        bif.rd_req_i   = 1'b0;
        bif.rd_adr_i   = '0;
        bif.rd_key_i   = '0;
        bif.rd_data_i  = '0;
        bif.rd_valid_i = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        bif.rd_req_i = 1'b1; bif.rd_data_i = 16'h5555; bif.rd_valid_i = 4'hF;
        #1 reset = 1'b0;
        #1;
        checks++; if (bif.out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", bif.out_valid_o); end
        checks++; if (bif.hit_count_o !== 2'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bif.hit_count_o); end
        step();  // reset still low across an edge: nothing loads
        checks++; if (bif.out_data_o !== 16'h0000) begin errors++; $display("FAIL reset_hold_data got %h exp 0000", bif.out_data_o); end
        reset = 1'b1;
    endtask

    task automatic test_passthrough();
        idle();
        bif.rd_req_i = 1'b1; bif.rd_key_i = 8'hAA; bif.rd_data_i = 16'h5555; bif.rd_valid_i = 4'hF;
        step();
        checks++; if (bif.out_valid_o !== 1'b1) begin errors++; $display("FAIL pass_valid got %0b exp 1", bif.out_valid_o); end
        checks++; if (bif.out_key_o !== 8'hAA) begin errors++; $display("FAIL pass_key got %h exp aa", bif.out_key_o); end
        checks++; if (bif.out_data_o !== 16'h5555) begin errors++; $display("FAIL pass_data got %h exp 5555", bif.out_data_o); end
        checks++; if (bif.out_is_valid_o !== 4'hF) begin errors++; $display("FAIL pass_isvalid got %h exp f", bif.out_is_valid_o); end
        checks++; if (bif.out_fwd_hit_o !== 4'h0) begin errors++; $display("FAIL pass_hit got %b exp 0000", bif.out_fwd_hit_o); end
        checks++; if (bif.hit_count_o !== 2'd0) begin errors++; $display("FAIL pass_count got %0d exp 0", bif.hit_count_o); end
    endtask

    task automatic test_fwd_prev();
        do_reset(); idle();
        bif.wr_we_i[1] = 1'b1; bif.wr_adr_i[1] = 2'd3; bif.wr_key_i[1] = 2'd1;
        bif.wr_data_i[1] = 4'd9; bif.wr_valid_i[1] = 1'b1;
        step(); idle();
        bif.rd_req_i = 1'b1; bif.rd_adr_i[1] = 2'd3; bif.rd_valid_i[1] = 1'b1;
        step();
        checks++; if (bif.out_data_o !== 16'h0090) begin errors++; $display("FAIL prev_data got %h exp 0090", bif.out_data_o); end
        checks++; if (bif.out_key_o !== 8'h04) begin errors++; $display("FAIL prev_key got %h exp 04", bif.out_key_o); end
        checks++; if (bif.out_fwd_hit_o !== 4'b0010) begin errors++; $display("FAIL prev_hit got %b exp 0010", bif.out_fwd_hit_o); end
        checks++; if (bif.hit_count_o !== 2'd1) begin errors++; $display("FAIL prev_count got %0d exp 1", bif.hit_count_o); end
    endtask

    task automatic test_back_to_back();
        do_reset(); idle();
        bif.wr_we_i[0] = 1'b1; bif.wr_adr_i[0] = 2'd2; bif.wr_key_i[0] = 2'd3;
        bif.wr_data_i[0] = 4'd6; bif.wr_valid_i[0] = 1'b1;
        bif.rd_req_i = 1'b1; bif.rd_adr_i[0] = 2'd2; bif.rd_valid_i[0] = 1'b1;
        step();
        checks++; if (bif.out_data_o !== 16'h0006) begin errors++; $display("FAIL same_data got %h exp 0006", bif.out_data_o); end
        checks++; if (bif.out_fwd_hit_o !== 4'b0001) begin errors++; $display("FAIL same_hit got %b exp 0001", bif.out_fwd_hit_o); end
        idle();
        bif.wr_we_i[0] = 1'b1; bif.wr_adr_i[0] = 2'd1; bif.wr_key_i[0] = 2'd1;
        bif.wr_data_i[0] = 4'd4; bif.wr_valid_i[0] = 1'b1;
        step();
        checks++; if (bif.out_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_noreq_valid got %0b exp 0", bif.out_valid_o); end
        bif.wr_key_i[0] = 2'd2; bif.wr_data_i[0] = 4'd7;
        step(); idle();
        bif.rd_req_i = 1'b1; bif.rd_adr_i[0] = 2'd1; bif.rd_valid_i[0] = 1'b1;
        step();
        checks++; if (bif.out_data_o !== 16'h0007) begin errors++; $display("FAIL b2b_data got %h exp 0007", bif.out_data_o); end
        checks++; if (bif.out_key_o !== 8'h02) begin errors++; $display("FAIL b2b_key got %h exp 02", bif.out_key_o); end
        checks++; if (bif.hit_count_o !== 2'd2) begin errors++; $display("FAIL b2b_count got %0d exp 2", bif.hit_count_o); end
    endtask

    task automatic test_window_expiry();
        do_reset(); idle();
        bif.wr_we_i[2] = 1'b1; bif.wr_adr_i[2] = 2'd1; bif.wr_data_i[2] = 4'hB; bif.wr_valid_i[2] = 1'b1;
        step(); idle();
        step();
        bif.rd_req_i = 1'b1; bif.rd_adr_i[2] = 2'd1; bif.rd_key_i[2] = 2'd2;
        bif.rd_data_i[2] = 4'd3; bif.rd_valid_i[2] = 1'b1;
        step();  // write issued DEPTH cycles before: still forwarded
        checks++; if (bif.out_data_o !== 16'h0B00) begin errors++; $display("FAIL edge_data got %h exp 0b00", bif.out_data_o); end
        checks++; if (bif.out_fwd_hit_o !== 4'b0100) begin errors++; $display("FAIL edge_hit got %b exp 0100", bif.out_fwd_hit_o); end
        step();  // DEPTH+1 cycles: raw RAM value
        checks++; if (bif.out_data_o !== 16'h0300) begin errors++; $display("FAIL expire_data got %h exp 0300", bif.out_data_o); end
        checks++; if (bif.out_key_o !== 8'h20) begin errors++; $display("FAIL expire_key got %h exp 20", bif.out_key_o); end
        checks++; if (bif.out_fwd_hit_o !== 4'b0000) begin errors++; $display("FAIL expire_hit got %b exp 0000", bif.out_fwd_hit_o); end
        checks++; if (bif.hit_count_o !== 2'd1) begin errors++; $display("FAIL expire_count got %0d exp 1", bif.hit_count_o); end
    endtask

    task automatic test_delete_flush();
        do_reset(); idle();
        bif.wr_we_i[3] = 1'b1; bif.wr_adr_i[3] = 2'd1; bif.wr_valid_i[3] = 1'b0;
        step(); idle();
        bif.rd_req_i = 1'b1; bif.rd_adr_i[3] = 2'd1; bif.rd_key_i[3] = 2'd1;
        bif.rd_data_i[3] = 4'd5; bif.rd_valid_i[3] = 1'b1;
        step();
        checks++; if (bif.out_is_valid_o !== 4'b0000) begin errors++; $display("FAIL del_isvalid got %b exp 0000", bif.out_is_valid_o); end
        checks++; if (bif.out_fwd_hit_o !== 4'b1000) begin errors++; $display("FAIL del_hit got %b exp 1000", bif.out_fwd_hit_o); end
        bif.flush_i = 1'b1;
        step();  // delete still sits in slot 0, but flush hides it
        checks++; if (bif.out_is_valid_o !== 4'b1000) begin errors++; $display("FAIL flush_isvalid got %b exp 1000", bif.out_is_valid_o); end
        checks++; if (bif.out_data_o !== 16'h5000) begin errors++; $display("FAIL flush_data got %h exp 5000", bif.out_data_o); end
        checks++; if (bif.out_fwd_hit_o !== 4'b0000) begin errors++; $display("FAIL flush_hit got %b exp 0000", bif.out_fwd_hit_o); end
        bif.wr_we_i[3] = 1'b1; bif.wr_adr_i[3] = 2'd2; bif.wr_key_i[3] = 2'd3;
        bif.wr_data_i[3] = 4'd8; bif.wr_valid_i[3] = 1'b1; bif.rd_adr_i[3] = 2'd2;
        step();  // flush cycle still forwards the current write
        checks++; if (bif.out_data_o !== 16'h8000) begin errors++; $display("FAIL flushwr_data got %h exp 8000", bif.out_data_o); end
        checks++; if (bif.hit_count_o !== 2'd2) begin errors++; $display("FAIL flushwr_count got %0d exp 2", bif.hit_count_o); end
        bif.flush_i = 1'b0; bif.wr_we_i = '0;
        step();  // write from the flush cycle was not captured
        checks++; if (bif.out_data_o !== 16'h5000) begin errors++; $display("FAIL flushwr_drop_data got %h exp 5000", bif.out_data_o); end
        checks++; if (bif.out_fwd_hit_o !== 4'b0000) begin errors++; $display("FAIL flushwr_drop_hit got %b exp 0000", bif.out_fwd_hit_o); end
    endtask

    task automatic test_stall();
        do_reset(); idle();
        bif.wr_we_i[1] = 1'b1; bif.wr_adr_i[1] = 2'd3; bif.wr_key_i[1] = 2'd1;
        bif.wr_data_i[1] = 4'd9; bif.wr_valid_i[1] = 1'b1;
        step(); idle();
        bif.rd_req_i = 1'b1; bif.rd_adr_i[1] = 2'd3; bif.rd_valid_i[1] = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            bif.clk_en = 1'b0;
            bif.flush_i = (i == 1);
            bif.wr_we_i[0] = 1'b1; bif.wr_adr_i[0] = 2'd0; bif.wr_key_i[0] = 2'd3;
            bif.wr_data_i[0] = 4'(12 + i); bif.wr_valid_i[0] = 1'b1;
            bif.rd_adr_i[0] = 2'd0; bif.rd_data_i[0] = 4'd1; bif.rd_valid_i[0] = 1'b1;
            step();
            checks++; if (bif.out_data_o !== 16'h0090) begin errors++; $display("FAIL stall_data[%0d] got %h exp 0090", i, bif.out_data_o); end
            checks++; if (bif.hit_count_o !== 2'd1) begin errors++; $display("FAIL stall_count[%0d] got %0d exp 1", i, bif.hit_count_o); end
        end
        idle();
        bif.rd_req_i = 1'b1;
        bif.rd_adr_i[1] = 2'd3; bif.rd_valid_i[1] = 1'b1;
        bif.rd_adr_i[0] = 2'd0; bif.rd_data_i[0] = 4'd1; bif.rd_valid_i[0] = 1'b1;
        step();  // window frozen: old table-1 write still in slot 0; stalled writes absent
        checks++; if (bif.out_data_o !== 16'h0091) begin errors++; $display("FAIL resume_data got %h exp 0091", bif.out_data_o); end
        checks++; if (bif.out_fwd_hit_o !== 4'b0010) begin errors++; $display("FAIL resume_hit got %b exp 0010", bif.out_fwd_hit_o); end
        checks++; if (bif.hit_count_o !== 2'd2) begin errors++; $display("FAIL resume_count got %0d exp 2", bif.hit_count_o); end
    endtask

    task automatic test_saturation_async_reset();
        logic [1:0] exp_cnt;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            idle();
            bif.wr_we_i[0] = 1'b1; bif.wr_adr_i[0] = 2'd1; bif.wr_data_i[0] = 4'(i + 1);
            bif.wr_valid_i[0] = 1'b1; bif.rd_req_i = 1'b1; bif.rd_adr_i[0] = 2'd1;
            step();
            exp_cnt = (i >= 2) ? 2'd3 : 2'(i + 1);
            checks++; if (bif.hit_count_o !== exp_cnt) begin errors++; $display("FAIL sat_count[%0d] got %0d exp %0d", i, bif.hit_count_o, exp_cnt); end
        end
        #2 reset = 1'b0;
        #1;
        checks++; if (bif.out_valid_o !== 1'b0 || bif.out_data_o !== 16'h0000) begin
            errors++; $display("FAIL async_rst_out got valid %0b data %h exp 0 0000", bif.out_valid_o, bif.out_data_o); end
        checks++; if (bif.hit_count_o !== 2'd0 || bif.out_fwd_hit_o !== 4'b0000) begin
            errors++; $display("FAIL async_rst_cnt got cnt %0d hit %b exp 0 0000", bif.hit_count_o, bif.out_fwd_hit_o); end
        #2 reset = 1'b1;
        idle();
        bif.rd_req_i = 1'b1; bif.rd_adr_i[0] = 2'd1; bif.rd_data_i[0] = 4'd2; bif.rd_valid_i[0] = 1'b1;
        step();  // first edge after release sees an empty window
        checks++; if (bif.out_data_o !== 16'h0002) begin errors++; $display("FAIL post_rst_data got %h exp 0002", bif.out_data_o); end
        checks++; if (bif.out_fwd_hit_o !== 4'b0000) begin errors++; $display("FAIL post_rst_hit got %b exp 0000", bif.out_fwd_hit_o); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_passthrough();
        test_fwd_prev();
        test_back_to_back();
        test_window_expiry();
        test_delete_flush();
        test_stall();
        test_saturation_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
